// File: rtl/card_pkg.sv
// ============================================================================
// card_pkg : shared constants, FSM state type and mask helper for card_deck
// Revision : 1.0
// ============================================================================
`default_nettype none

package card_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  localparam logic [3:0] RANK_A = 4'd1;
  localparam logic [3:0] RANK_J = 4'd11;
  localparam logic [3:0] RANK_Q = 4'd12;
  localparam logic [3:0] RANK_K = 4'd13;

  // Galois feedback for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SHUF  = 2'd1,
    READY = 2'd2
  } state_e;

  // Smallest 2^k-1 that is >= v: smear the top set bit downwards.
  function automatic logic [5:0] mask6(input logic [5:0] v);
    logic [5:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/card_deck_if.sv
// ============================================================================
// card_deck_if : draw/shuffle handshake between card_deck and its consumer
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface card_deck_if;

  logic       shuffle;
  logic       pip;
  logic [3:0] number;
  logic       valid;
  logic       empty;
  logic       busy;

  modport master (
    output shuffle,
    output pip,
    input  number,
    input  valid,
    input  empty,
    input  busy
  );

  modport slave (
    input  shuffle,
    input  pip,
    output number,
    output valid,
    output empty,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16   : free-running 16-bit Galois LFSR, reloaded only by reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr16
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = (lfsr_q >> 1) ^ ({16{lfsr_q[0]}} & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/card_deck.sv
// ============================================================================
// card_deck : 52-card deck with in-place LFSR Fisher-Yates shuffle and dealer
// Revision  : 1.0
// ============================================================================
`default_nettype none

module card_deck #(
  parameter int          DECK_SIZE  = card_pkg::DECK_SIZE,
  parameter int          RANKS      = card_pkg::RANKS,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter bit          SHUFFLE_EN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  card_deck_if.slave bus
);

  import card_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
  localparam logic [5:0] DECK_END = 6'(DECK_SIZE);
  localparam logic [3:0] TOP_RANK = 4'(RANKS);

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] ptr_q, ptr_d;
  logic [3:0] rank_q, rank_d;
  logic [3:0] number_q, number_d;
  logic       valid_q, valid_d;

  logic [15:0] lfsr_w;
  logic [5:0]  cand;
  logic        fill_we;
  logic        swap_en;
  logic        empty;
  logic [3:0]  deck_q [DECK_SIZE];

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q_o   (lfsr_w)
  );

  assign cand  = 6'(lfsr_w) & mask6(idx_q);
  assign empty = (state_q != READY) || (ptr_q == DECK_END);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    rank_d   = rank_q;
    number_d = number_q;
    valid_d  = 1'b0;
    fill_we  = 1'b0;
    swap_en  = 1'b0;

    // A shuffle request overrides everything, including a same-cycle pip.
    if (bus.shuffle) begin
      state_d  = FILL;
      idx_d    = '0;
      ptr_d    = '0;
      rank_d   = RANK_A;
      number_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          fill_we = 1'b1;
          rank_d  = (rank_q == TOP_RANK) ? RANK_A : rank_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = SHUFFLE_EN ? SHUF : READY;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        SHUF: begin
          // Out-of-range candidates are rejected and retried next cycle.
          if (cand <= idx_q) begin
            swap_en = 1'b1;
            idx_d   = idx_q - 6'd1;
            if (idx_q == 6'd1) begin
              state_d = READY;
            end
          end
        end
        READY: begin
          if (bus.pip && !empty) begin
            number_d = deck_q[ptr_q];
            valid_d  = 1'b1;
            ptr_d    = ptr_q + 6'd1;
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = '0;
          ptr_d   = '0;
          rank_d  = RANK_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      idx_q    <= '0;
      ptr_q    <= '0;
      rank_q   <= RANK_A;
      number_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      rank_q   <= rank_d;
      number_q <= number_d;
      valid_q  <= valid_d;
    end
  end

  // Deck storage carries no reset; it is always rewritten by FILL.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      deck_q[idx_q] <= rank_q;
    end else if (swap_en) begin
      deck_q[idx_q] <= deck_q[cand];
      deck_q[cand]  <= deck_q[idx_q];
    end
  end

  assign bus.number = number_q;
  assign bus.valid  = valid_q;
  assign bus.empty  = empty;
  assign bus.busy   = (state_q != READY);

endmodule

`default_nettype wire

// File: tb/tb_card_deck.sv
// ============================================================================
// tb_card_deck : directed bench for card_deck (fill-order and shuffled decks)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_card_deck;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  card_deck_if bus0 ();
  card_deck_if bus1 ();

  card_deck #(
    .SHUFFLE_EN (1'b0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  card_deck #(
    .SHUFFLE_EN (1'b1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] seq_cur [52];
  logic [3:0] seq_a   [52];
  int         hist    [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0(output int n);
    n = 0;
    while (bus0.busy && n < 5000) begin
      tick();
      n++;
    end
    check("ready0_timeout", 32'(bus0.busy), 32'(0));
  endtask

  // 52 back-to-back deals on the unshuffled deck: 1..13 four times.
  task automatic deal_fill0();
    bus0.pip = 1'b1;
    for (int k = 0; k < 52; k++) begin
      tick();
      if (k == 51) bus0.pip = 1'b0;
      check("fill_valid",  32'(bus0.valid),  32'(1));
      check("fill_number", 32'(bus0.number), 32'((k % 13) + 1));
      check("fill_empty",  32'(bus0.empty),  32'(k == 51));
    end
  endtask

  // Reset both decks, hold pip on dut1 from release, record its 52 deals.
  task automatic run1(output int t);
    int bv;
    rst_n = 1'b0;
    tick();
    check("rst1_number", 32'(bus1.number), 32'(0));
    check("rst1_valid",  32'(bus1.valid),  32'(0));
    check("rst1_empty",  32'(bus1.empty),  32'(1));
    check("rst1_busy",   32'(bus1.busy),   32'(1));
    rst_n    = 1'b1;
    bus1.pip = 1'b1;
    t  = 0;
    bv = 0;
    while (bus1.busy && t < 5000) begin
      tick();
      t++;
      if (bus1.valid) bv++;
    end
    check("ready1_timeout",   32'(bus1.busy), 32'(0));
    check("busy_pip_ignored", 32'(bv),        32'(0));
    check("shuf_min_latency", 32'(t >= 103),  32'(1));
    for (int k = 0; k < 52; k++) begin
      tick();
      check("shuf_valid", 32'(bus1.valid), 32'(1));
      check("shuf_empty", 32'(bus1.empty), 32'(k == 51));
      seq_cur[k] = bus1.number;
    end
    tick();
    check("over1_valid",  32'(bus1.valid),  32'(0));
    check("over1_number", 32'(bus1.number), 32'(seq_cur[51]));
    check("over1_empty",  32'(bus1.empty),  32'(1));
    bus1.pip = 1'b0;
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    int bad;
    int diffs;

    bus0.pip     = 1'b0;
    bus0.shuffle = 1'b0;
    bus1.pip     = 1'b0;
    bus1.shuffle = 1'b0;

    tick();
    tick();
    check("rst0_number", 32'(bus0.number), 32'(0));
    check("rst0_valid",  32'(bus0.valid),  32'(0));
    check("rst0_empty",  32'(bus0.empty),  32'(1));
    check("rst0_busy",   32'(bus0.busy),   32'(1));

    // Fill-order deck: ready after exactly 52 cycles, no shuffle pulse needed.
    rst_n = 1'b1;
    wait_ready0(n);
    check("fill_cycles", 32'(n), 32'(52));
    check("ready0_empty", 32'(bus0.empty), 32'(0));
    deal_fill0();

    // Draw past exhaustion.
    bus0.pip = 1'b1;
    tick();
    bus0.pip = 1'b0;
    check("over0_valid",  32'(bus0.valid),  32'(0));
    check("over0_number", 32'(bus0.number), 32'(13));
    check("over0_empty",  32'(bus0.empty),  32'(1));

    // Shuffled deck: rank histogram and order.
    run1(t1);
    for (int v = 0; v < 16; v++) hist[v] = 0;
    bad   = 0;
    diffs = 0;
    for (int k = 0; k < 52; k++) begin
      seq_a[k] = seq_cur[k];
      hist[seq_cur[k]]++;
      if (seq_cur[k] == 4'd0 || seq_cur[k] > 4'd13) bad++;
      if (32'(seq_cur[k]) != 32'((k % 13) + 1)) diffs++;
    end
    for (int v = 1; v <= 13; v++) begin
      check("hist_rank", 32'(hist[v]), 32'(4));
    end
    check("bad_ranks", 32'(bad), 32'(0));
    check("order_differs", 32'(diffs > 0), 32'(1));

    // Same seed and same release-to-pip timing: identical sequence.
    run1(t2);
    check("det_latency", 32'(t2), 32'(t1));
    for (int k = 0; k < 52; k++) begin
      check("det_card", 32'(seq_cur[k]), 32'(seq_a[k]));
    end

    // dut0 refilled during the reruns; deal 10 then shuffle with a pip.
    check("ready0_again", 32'(bus0.busy), 32'(0));
    bus0.pip = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("pre_valid",  32'(bus0.valid),  32'(1));
      check("pre_number", 32'(bus0.number), 32'(k + 1));
    end
    bus0.shuffle = 1'b1;
    tick();
    bus0.shuffle = 1'b0;
    bus0.pip     = 1'b0;
    check("shf_valid",  32'(bus0.valid),  32'(0));
    check("shf_busy",   32'(bus0.busy),   32'(1));
    check("shf_number", 32'(bus0.number), 32'(0));
    check("shf_empty",  32'(bus0.empty),  32'(1));
    wait_ready0(n);
    check("refill_cycles", 32'(n), 32'(52));
    deal_fill0();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/card_deck.md
Name: card_deck

Overview:
- Upstream card source for the ten-thirty game controller. Holds a 52-card deck in a register array and shuffles it in hardware with an LFSR-driven Fisher-Yates pass.
- Deals one card per draw request (pip) on a 4-bit rank bus (number), with an empty flag.
- The consumer drives pip from a register and reads number/empty as wires.

Parameters:
- DECK_SIZE, 52, total cards; must equal SUITS*RANKS.
- RANKS, 13, ranks per suit; encoded 1..13 (1=A, 11=J, 12=Q, 13=K).
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- SHUFFLE_EN, 1, 0 skips the shuffle and leaves the deck in fill order (verification mode).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- shuffle  input  1  single-cycle pulse; restarts fill+shuffle.
- pip  input  1  draw request, sampled each cycle.
- number  output  4  rank of the last dealt card, 1..13; 0 after reset/shuffle until the first deal.
- valid  output  1  one-cycle pulse: number updated this cycle.
- empty  output  1  no card available (busy or exhausted).
- busy  output  1  fill/shuffle in progress.

Behaviour:
- Reset values: number=0, valid=0, empty=1, busy=1. FSM enters FILL directly on reset release, with no shuffle pulse needed. LFSR=SEED, ptr=0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Free-runs every cycle in all states, so shuffle timing contributes entropy.
- FSM states: FILL, SHUF, READY.
- FILL:
  - One slot per cycle: deck[i] = (i mod RANKS)+1, i from 0 to DECK_SIZE-1, so 52 cycles.
  - Then go to SHUF with i=DECK_SIZE-1, or to READY if SHUFFLE_EN=0.
- SHUF:
  - Each cycle, cand = lfsr[5:0] & mask(i), where mask is the smallest 2^k-1 >= i.
  - If cand <= i: swap deck[i] and deck[cand] in the same cycle, then i = i-1.
  - Otherwise reject and retry next cycle.
  - When i reaches 0, go to READY. Latency is variable, at least 51 cycles.
- READY:
  - ptr=0, busy=0, empty=(ptr==DECK_SIZE).
  - pip accepted when READY and !empty.
  - Next cycle: number=deck[ptr], valid=1, ptr=ptr+1. Single-cycle latency; back-to-back pips every cycle are supported.
- Last card: the pip that takes ptr to DECK_SIZE sets empty=1 in the same cycle valid rises.
- pip while empty or busy is ignored: no valid, number unchanged, no error.
- shuffle in any state: next cycle go to FILL, with busy=1, empty=1, ptr=0, number=0, valid=0.
  - A pip in the same cycle as shuffle is dropped (shuffle wins).
  - Shuffle during FILL/SHUF restarts FILL from i=0.
- The LFSR is never reloaded except by rst_n. A shuffle does not reseed.
- Asynchronous reset mid-operation: all state returns to reset values immediately and deck contents are don't-care. The deck is refilled on release.
- Widths: ptr and i are 6 bits. cand is 6 bits and is always < 64.

Decomposition:
- Package card_pkg holds:
  - DECK_SIZE, RANKS.
  - Rank constants RANK_A=1, RANK_J=11, RANK_Q=12, RANK_K=13.
  - FSM state enum {FILL, SHUF, READY}.
  - LFSR_TAPS.
- Sub-module lfsr16 (clk, rst_n, seed param, q[15:0]), free-running and reused by other random sources.
- Deck array, FSM and deal logic stay in card_deck.

Test Plan:
- SHUFFLE_EN=0, reset, wait !busy (52 cycles), then 52 pips → number sequence 1..13 repeated four times. empty=1 in the cycle of the 52nd valid.
- SHUFFLE_EN=1, reset, then 52 pips → histogram shows exactly four of each value 1..13. No 0 and no value >13 appear. Order differs from fill order.
- 53rd pip after exhaustion → valid stays 0, number holds the 52nd value, empty stays 1.
- pip held high throughout busy → no valid until busy falls; then one valid per cycle, 52 total.
- After 10 deals, pulse shuffle together with pip → pip dropped, busy=1, number=0. After !busy, 52 further deals are available.
- Same SEED, same reset-release-to-first-pip cycle count, run twice → identical 52-card sequences (determinism check).
